mem_copy_engine: RTL and testbench

Memory-side initiator that drives the single-port data RAM (`we`, `a`, `wd`, `rd`) to copy a block of words from a source region to a destination region. It sits between a control source (CPU peripheral register or test bench) and the RAM port, and sequences read and write cycles so the RAM needs no knowledge of the transfer. Overlapping regions are handled with memmove semantics.

---
 rtl/mem_copy_engine.sv | 135 +++++++++++++
 tb/tb_mem_copy_engine.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// Block copy engine driving a single-port RAM with memmove semantics.
// Two cycles per word: READ captures the source word, WRITE stores it.
module mem_copy_engine #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int LW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] src_ptr;
    logic [AW-1:0] dst_ptr;
    logic [LW-1:0] cnt;
    logic [DW-1:0] data_q;
    logic          bwd;

    logic [AW-1:0] len_ext;
    logic [AW:0]   src_end;
    logic          go_bwd;
    logic [AW-1:0] one;

    assign one     = {{(AW-1){1'b0}}, 1'b1};
    assign len_ext = {{(AW-LW){1'b0}}, len};
    // Unwrapped end so a region ending past all-ones still compares correctly
    assign src_end = {1'b0, src} + {1'b0, len_ext};
    assign go_bwd  = (dst > src) && ({1'b0, dst} < src_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (len == '0) ? DONE : READ;
                end
            end
            READ:  state_nx = WRITE;
            WRITE: state_nx = (cnt == {{(LW-1){1'b0}}, 1'b1}) ? DONE : READ;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_we = 1'b0;
        mem_a  = '0;
        mem_wd = '0;
        unique case (state)
            READ: begin
                mem_a = src_ptr;
            end
            WRITE: begin
                mem_a  = dst_ptr;
                mem_wd = data_q;
                mem_we = 1'b1;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    assign busy = (state == READ) || (state == WRITE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_ptr <= '0;
            dst_ptr <= '0;
            cnt     <= '0;
            data_q  <= '0;
            bwd     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cnt <= len;
                        bwd <= go_bwd;
                        if (go_bwd) begin
                            src_ptr <= src + len_ext - one;
                            dst_ptr <= dst + len_ext - one;
                        end else begin
                            src_ptr <= src;
                            dst_ptr <= dst;
                        end
                    end
                end
                READ: begin
                    data_q <= mem_rd;
                end
                WRITE: begin
                    cnt <= cnt - {{(LW-1){1'b0}}, 1'b1};
                    if (bwd) begin
                        src_ptr <= src_ptr - one;
                        dst_ptr <= dst_ptr - one;
                    end else begin
                        src_ptr <= src_ptr + one;
                        dst_ptr <= dst_ptr + one;
                    end
                end
                default: begin
                    cnt <= cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: vector table, corner sequences,
// and random copies checked against a memmove reference over a 256-word RAM.
module tb_mem_copy_engine;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 16;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    mem_copy_engine #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .src    (src),
        .dst    (dst),
        .len    (len),
        .busy   (busy),
        .done   (done),
        .mem_we (mem_we),
        .mem_a  (mem_a),
        .mem_wd (mem_wd),
        .mem_rd (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM aliases addresses modulo 256
    logic [31:0] ram   [256];
    logic [31:0] img   [256];
    logic [31:0] model [256];
    logic        load;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) ram[i] <= img[i];
        end else if (mem_we) begin
            ram[mem_a[7:0]] <= mem_wd;
        end
    end

    assign mem_rd = ram[mem_a[7:0]];

    int n_cmp;
    int n_bad;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int mem_diff();
        int n = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== model[i]) n++;
        return n;
    endfunction

    task automatic base_img();
        for (int i = 0; i < 256; i++) img[i] = 32'hA000_0000 + 32'(i * 7);
        for (int i = 0; i < 4; i++) img[i] = 32'(24 + i);
        for (int i = 0; i < 4; i++) img[10 + i] = 32'(1 + i);
    endtask

    task automatic load_img();
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 256; i++) model[i] = img[i];
    endtask

    // memmove: snapshot the whole source block, then write it out
    task automatic model_copy(input logic [31:0] s, input logic [31:0] d,
                              input int l);
        logic [31:0] q[$];
        logic [31:0] a;
        q = {};
        for (int i = 0; i < l; i++) begin
            a = s + 32'(i);
            q.push_back(model[a[7:0]]);
        end
        for (int i = 0; i < l; i++) begin
            a = d + 32'(i);
            model[a[7:0]] = q[i];
        end
    endtask

    task automatic run_copy(input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] l, input int inj,
                            output int dcyc, output int dcnt,
                            output int wcnt, output logic [31:0] fwa,
                            output int bcnt);
        dcyc = -1;
        dcnt = 0;
        wcnt = 0;
        bcnt = 0;
        fwa  = '0;
        @(negedge clk);
        src   = s;
        dst   = d;
        len   = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 2 * int'(l) + 4; c++) begin
            if (c == inj) begin
                start = 1'b1;
                src   = '0;
                dst   = 32'd40;
                len   = 16'd4;
            end else begin
                start = 1'b0;
            end
            if (mem_we) begin
                if (wcnt == 0) fwa = mem_a;
                wcnt++;
            end
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                if (dcyc < 0) dcyc = c;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic [31:0] s;
        logic [31:0] d;
        logic [15:0] l;
        logic [31:0] fwa;
        int          dcyc;
    } vec_t;

    vec_t vt[7];

    initial begin
        int          dcyc;
        int          dcnt;
        int          wcnt;
        int          bcnt;
        int          di;
        logic [31:0] fwa;
        logic [31:0] rs;
        logic [31:0] rd;
        logic [15:0] rl;

        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        start = 1'b0;
        load  = 1'b0;
        src   = '0;
        dst   = '0;
        len   = '0;

        vt[0] = '{32'd0, 32'd25, 16'd4, 32'd25, 9};
        vt[1] = '{32'd10, 32'd8, 16'd4, 32'd8, 9};
        vt[2] = '{32'd10, 32'd12, 16'd4, 32'd15, 9};
        vt[3] = '{32'd5, 32'd7, 16'd0, 32'd0, 1};
        vt[4] = '{32'd0, 32'd0, 16'd3, 32'd0, 7};
        vt[5] = '{32'hFFFF_FFFE, 32'd100, 16'd4, 32'd100, 9};
        vt[6] = '{32'd50, 32'hFFFF_FFFF, 16'd3, 32'hFFFF_FFFF, 7};

        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_a", mem_a, 0);
        chk("rst_wd", mem_wd, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            base_img();
            load_img();
            run_copy(vt[v].s, vt[v].d, vt[v].l, 0, dcyc, dcnt, wcnt, fwa,
                     bcnt);
            model_copy(vt[v].s, vt[v].d, int'(vt[v].l));
            chk($sformatf("v%0d_done_cyc", v), 64'(dcyc), 64'(vt[v].dcyc));
            chk($sformatf("v%0d_done_cnt", v), 64'(dcnt), 1);
            chk($sformatf("v%0d_we_cnt", v), 64'(wcnt), 64'(vt[v].l));
            chk($sformatf("v%0d_busy_cnt", v), 64'(bcnt), 64'(2 * vt[v].l));
            if (vt[v].l != 0)
                chk($sformatf("v%0d_first_wa", v), fwa, vt[v].fwa);
            chk($sformatf("v%0d_ram", v), 64'(mem_diff()), 0);
        end

        // start during an active copy must be dropped
        base_img();
        load_img();
        run_copy(32'd0, 32'd25, 16'd4, 3, dcyc, dcnt, wcnt, fwa, bcnt);
        model_copy(32'd0, 32'd25, 4);
        chk("ign_done_cnt", 64'(dcnt), 1);
        chk("ign_we_cnt", 64'(wcnt), 4);
        chk("ign_ram", 64'(mem_diff()), 0);

        // reset during the third WRITE
        base_img();
        load_img();
        @(negedge clk);
        src   = 32'd0;
        dst   = 32'd25;
        len   = 16'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_we", mem_we, 1);
        chk("mid_a", mem_a, 27);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out", {busy, done, mem_we, mem_a, mem_wd}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt  = 0;
        for (int c = 0; c < 8; c++) begin
            if (done || busy) dcnt++;
            @(negedge clk);
        end
        chk("mid_no_done", 64'(dcnt), 0);
        model[25] = img[0];
        model[26] = img[1];
        chk("mid_ram", 64'(mem_diff()), 0);
        run_copy(32'd0, 32'd25, 16'd4, 0, dcyc, dcnt, wcnt, fwa, bcnt);
        model_copy(32'd0, 32'd25, 4);
        chk("post_done_cyc", 64'(dcyc), 9);
        chk("post_ram", 64'(mem_diff()), 0);

        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 256; i++) img[i] = $urandom;
            load_img();
            rl = 16'($urandom_range(0, 20));
            rs = 32'($urandom_range(0, 200));
            if (r % 2 == 0) begin
                di = int'(rs) + int'($urandom_range(0, 2 * int'(rl)))
                     - int'(rl);
                if (di < 0) di = 0;
                rd = 32'(di);
            end else begin
                rd = 32'($urandom_range(0, 200));
            end
            run_copy(rs, rd, rl, 0, dcyc, dcnt, wcnt, fwa, bcnt);
            model_copy(rs, rd, int'(rl));
            chk($sformatf("rnd%0d_done_cyc", r), 64'(dcyc),
                64'(2 * int'(rl) + 1));
            chk($sformatf("rnd%0d_we_cnt", r), 64'(wcnt), 64'(rl));
            chk($sformatf("rnd%0d_ram", r), 64'(mem_diff()), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_bad);
        $finish;
    end

endmodule
